interp_span_walker: RTL

//   Span walker directly upstream of the per-pixel perspective interpolator.

---
 rtl/interp_pkg.sv | 24 ++
 rtl/interp_step_acc.sv | 43 ++++
 rtl/interp_span_walker.sv | 111 +++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// Shared types and default sizes for the span walker and its accumulator.
// Optional q clamp is selected with the SPAN_QCLAMP_EN macro in the top module.
package interp_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 16;
    localparam int XW_DEF    = 12;
    localparam int LW_DEF    = 12;

    typedef struct packed {
        logic [XW_DEF-1:0]    x0;
        logic [LW_DEF-1:0]    len;
        logic [WIDTH_DEF-1:0] v0;
        logic [WIDTH_DEF-1:0] q0;
        logic [WIDTH_DEF-1:0] dv;
        logic [WIDTH_DEF-1:0] dq;
    } span_desc_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } walk_state_t;

endpackage

// File: rtl/interp_step_acc.sv
// v/w and 1/w accumulators: load seeds the start values and gradients,
// step adds the gradients once (two's-complement wrap).
module interp_step_acc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] v0,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] dv,
    input  logic [WIDTH-1:0] dq,
    output logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] v_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dv_reg;
    logic [WIDTH-1:0] dq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg  <= '0;
            q_reg  <= '0;
            dv_reg <= '0;
            dq_reg <= '0;
        end else if (load) begin
            v_reg  <= v0;
            q_reg  <= q0;
            dv_reg <= dv;
            dq_reg <= dq;
        end else if (step) begin
            v_reg <= v_reg + dv_reg;
            q_reg <= q_reg + dq_reg;
        end
    end

    assign v = v_reg;
    assign q = q_reg;

endmodule

// File: rtl/interp_span_walker.sv
// Walks one span descriptor into a stream of pixels with incremental v/w, 1/w.
// Define SPAN_QCLAMP_EN to force pix_q to 1 LSB whenever the q accumulator is <= 0.
module interp_span_walker
    import interp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int XW    = XW_DEF,
    parameter int LW    = LW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             span_valid,
    output logic             span_ready,
    input  logic [XW-1:0]    span_x0,
    input  logic [LW-1:0]    span_len,
    input  logic [WIDTH-1:0] span_v0,
    input  logic [WIDTH-1:0] span_q0,
    input  logic [WIDTH-1:0] span_dv,
    input  logic [WIDTH-1:0] span_dq,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [XW-1:0]    pix_x,
    output logic [WIDTH-1:0] pix_v,
    output logic [WIDTH-1:0] pix_q,
    output logic             pix_last,
    output logic             busy
);

    if (FRAC >= WIDTH) begin : g_bad_frac
        $error("FRAC must be smaller than WIDTH");
    end

    walk_state_t      state_reg;
    logic [XW-1:0]    x_reg;
    logic [LW-1:0]    rem_reg;
    logic             valid_reg;
    logic             last_reg;

    logic             span_hs;
    logic             pix_hs;
    logic             span_load;
    logic             acc_step;
    logic [WIDTH-1:0] acc_v;
    logic [WIDTH-1:0] acc_q;

    assign pix_hs     = valid_reg & pix_ready;
    // Ready during the final pixel handshake so spans chain without a bubble.
    assign span_ready = (state_reg == IDLE) | (pix_hs & last_reg);
    assign span_hs    = span_valid & span_ready;
    assign span_load  = span_hs & (span_len != '0);
    assign acc_step   = pix_hs & ~last_reg & ~span_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            rem_reg   <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (span_load) begin
            state_reg <= WALK;
            x_reg     <= span_x0;
            rem_reg   <= span_len;
            valid_reg <= 1'b1;
            last_reg  <= (span_len == LW'(1));
        end else if (pix_hs) begin
            if (last_reg) begin
                state_reg <= IDLE;
                rem_reg   <= '0;
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
            end else begin
                x_reg    <= x_reg + XW'(1);
                rem_reg  <= rem_reg - LW'(1);
                last_reg <= (rem_reg == LW'(2));
            end
        end
    end

    interp_step_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (span_load),
        .step  (acc_step),
        .v0    (span_v0),
        .q0    (span_q0),
        .dv    (span_dv),
        .dq    (span_dq),
        .v     (acc_v),
        .q     (acc_q)
    );

    assign pix_valid = valid_reg;
    assign pix_x     = x_reg;
    assign pix_v     = acc_v;
    assign pix_last  = last_reg;
    assign busy      = (state_reg == WALK);

`ifdef SPAN_QCLAMP_EN
    // Only clamp while a pixel is presented so the idle/reset value stays 0.
    logic q_nonpos;
    assign q_nonpos = acc_q[WIDTH-1] | (acc_q == '0);
    assign pix_q    = (valid_reg & q_nonpos) ? WIDTH'(1) : acc_q;
`else
    assign pix_q = acc_q;
`endif

endmodule
